// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package disp_pkg;

  typedef enum logic {
    S_DEAD = 1'b0,
    S_ON   = 1'b1
  } scan_state_t;

  localparam int SEG_W = 7;
  localparam int NIB_W = 4;

  // Active-high "all segments off"; the scanner flips it for active-low boards.
  localparam logic [SEG_W-1:0] SEG_OFF_HI = 7'b0000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/module_disp_dec.sv
// Hex nibble to active-high 7-segment pattern, bit6=a .. bit0=g.
module module_disp_dec
  import disp_pkg::*;
(
  input  logic [NIB_W-1:0] hex_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF_HI;
    case (hex_i)
      4'h0: seg_o = 7'b1111110;
      4'h1: seg_o = 7'b0110000;
      4'h2: seg_o = 7'b1101101;
      4'h3: seg_o = 7'b1111001;
      4'h4: seg_o = 7'b0110011;
      4'h5: seg_o = 7'b1011011;
      4'h6: seg_o = 7'b1011111;
      4'h7: seg_o = 7'b1110000;
      4'h8: seg_o = 7'b1111111;
      4'h9: seg_o = 7'b1111011;
      4'hA: seg_o = 7'b1110111;
      4'hB: seg_o = 7'b0011111;
      4'hC: seg_o = 7'b1001110;
      4'hD: seg_o = 7'b0111101;
      4'hE: seg_o = 7'b1001111;
      4'hF: seg_o = 7'b1000111;
      default: seg_o = SEG_OFF_HI;
    endcase
  end

endmodule

// File: rtl/module_disp_scan.sv
// Time-multiplexed N-digit 7-segment scanner with frame-aligned double buffering
// and a dark gap between digits. Interface: load_i is a fire-and-forget strobe (no ready).
module module_disp_scan
  import disp_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_CYC    = 50000,
  parameter int DEAD_CYC       = 500,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [NIB_W*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]       blank_i,
  output logic [N_DIGITS-1:0]       an_o,
  output logic [SEG_W-1:0]          seg_o,
  output logic                      upd_o,
  output logic                      frame_o
);

  localparam int CNT_W = $clog2(max_int(REFRESH_CYC, DEAD_CYC) + 1);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW    = NIB_W * N_DIGITS;

  localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [SEG_W-1:0]    SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_OFF_HI : SEG_OFF_HI;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(REFRESH_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  scan_state_t             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pend_q, pend_d;
  logic [DW-1:0]           sh_data_q, sh_data_d;
  logic [N_DIGITS-1:0]     sh_mask_q, sh_mask_d;
  logic [DW-1:0]           act_data_q, act_data_d;
  logic [N_DIGITS-1:0]     act_mask_q, act_mask_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic [SEG_W-1:0]        seg_q, seg_d;

  logic                    commit;
  logic [NIB_W-1:0]        nib_sel;
  logic                    mask_sel;
  logic [N_DIGITS-1:0]     onehot;
  logic [SEG_W-1:0]        dec_seg;

  module_disp_dec u_dec (
    .hex_i (nib_sel),
    .seg_o (dec_seg)
  );

  assign commit  = (state_q == S_DEAD) && (idx_q == '0) && (cnt_q == '0) && pend_q;
  assign upd_o   = commit;
  assign frame_o = (state_q == S_ON) && (idx_q == IDX_LAST) && (cnt_q == ON_LAST);
  assign an_o    = an_q;
  assign seg_o   = seg_q;

  // Shadow/active buffering: the commit reads the old shadow, a same-cycle load refills it.
  always_comb begin
    pend_d     = pend_q;
    sh_data_d  = sh_data_q;
    sh_mask_d  = sh_mask_q;
    act_data_d = act_data_q;
    act_mask_d = act_mask_q;
    if (commit) begin
      act_data_d = sh_data_q;
      act_mask_d = sh_mask_q;
      pend_d     = 1'b0;
    end
    if (load_i) begin
      sh_data_d = data_i;
      sh_mask_d = blank_i;
      pend_d    = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = S_DEAD;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_DEAD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so pins move with the state change.
  always_comb begin
    nib_sel  = '0;
    mask_sel = 1'b1;
    onehot   = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib_sel   = act_data_d[k*NIB_W +: NIB_W];
        mask_sel  = act_mask_d[k];
        onehot[k] = 1'b1;
      end
    end
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if ((state_d == S_ON) && !mask_sel) begin
      an_d  = AN_OFF ^ onehot;
      seg_d = SEG_ACTIVE_LOW ? ~dec_seg : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_DEAD;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      sh_data_q  <= '0;
      sh_mask_q  <= '1;
      act_data_q <= '0;
      act_mask_q <= '1;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      sh_data_q  <= sh_data_d;
      sh_mask_q  <= sh_mask_d;
      act_data_q <= act_data_d;
      act_mask_q <= act_mask_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

endmodule

// File: tb/tb_module_disp_scan.sv
// Scoreboard bench: a frame-position reference model predicts every output cycle.
module tb_module_disp_scan;

  localparam int N  = 4;
  localparam int R  = 3;
  localparam int D  = 1;
  localparam int SL = D + R;
  localparam int P  = N * SL;
  localparam int EW = N + 7 + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_i = 1'b0;
  logic [4*N-1:0] data_i = '0;
  logic [N-1:0]  blank_i = '0;
  logic [N-1:0]  an_o;
  logic [6:0]    seg_o;
  logic          upd_o;
  logic          frame_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];

  logic [6:0] seg_tab [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Reference model: frame position plus shadow/active buffers.
  int             m_c = 0;
  bit             m_live = 0;
  logic           m_pend;
  logic [4*N-1:0] m_sh_d, m_act_d;
  logic [N-1:0]   m_sh_m, m_act_m;

  module_disp_scan #(
    .N_DIGITS(N), .REFRESH_CYC(R), .DEAD_CYC(D),
    .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .load_i(load_i), .data_i(data_i), .blank_i(blank_i),
    .an_o(an_o), .seg_o(seg_o), .upd_o(upd_o), .frame_o(frame_o)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] model_out(input int c, input logic pend,
                                              input logic [4*N-1:0] ad, input logic [N-1:0] am);
    int pos, slot, off;
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic [3:0]   nib;
    logic         upd, frm;
    pos  = c % P;
    slot = pos / SL;
    off  = pos % SL;
    an   = '1;
    seg  = 7'h7F;
    if (off >= D && !am[slot]) begin
      nib = ad[slot*4 +: 4];
      an  = ~(N'(1) << slot);
      seg = ~seg_tab[nib];
    end
    upd = (pos == 0) && pend;
    frm = (slot == N-1) && (off == SL-1);
    return {an, seg, upd, frm};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_live  = 1;
      m_c     = 0;
      m_pend  = 1'b0;
      m_sh_d  = '0;
      m_sh_m  = '1;
      m_act_d = '0;
      m_act_m = '1;
      exp_q.push_back(model_out(m_c, m_pend, m_act_d, m_act_m));
    end else if (m_live) begin
      if ((m_c % P) == 0 && m_pend) begin
        m_act_d = m_sh_d;
        m_act_m = m_sh_m;
        m_pend  = 1'b0;
      end
      if (load_i) begin
        m_sh_d = data_i;
        m_sh_m = blank_i;
        m_pend = 1'b1;
      end
      m_c++;
      exp_q.push_back(model_out(m_c, m_pend, m_act_d, m_act_m));
    end
  end

  // ---- monitor / scoreboard ----
  always @(negedge clk) begin
    logic [EW-1:0] e, a;
    if (m_live) begin
      n_tests++;
      a = {an_o, seg_o, upd_o, frame_o};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t got an=%b seg=%b", $time, an_o, seg_o);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs c=%0d got an=%b seg=%b upd=%b frame=%b exp an=%b seg=%b upd=%b frame=%b",
                   m_c, a[EW-1 -: N], a[8:2], a[1], a[0], e[EW-1 -: N], e[8:2], e[1], e[0]);
        end
      end
    end
  end

  // ---- driver tasks ----
  task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] b);
    load_i  = 1'b1;
    data_i  = d;
    blank_i = b;
    @(negedge clk);
    load_i  = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int i;
    i = 0;
    while ((m_c % P) != p && i < 4*P) begin
      @(negedge clk);
      i++;
    end
    n_tests++;
    if ((m_c % P) != p) begin
      n_fail++;
      $display("FAIL wait_pos got pos=%0d exp pos=%0d", m_c % P, p);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    do_load(16'h12AF, 4'b0000);
    repeat (40) @(negedge clk);

    wait_pos(6);
    do_load(16'h1111, 4'b0000);
    repeat (2) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    repeat (40) @(negedge clk);

    wait_pos(0);
    do_load(16'h0005, 4'b0000);
    repeat (40) @(negedge clk);

    do_load(16'h9C3E, 4'b1000);
    repeat (40) @(negedge clk);

    do_load(16'h7B4D, 4'b0000);
    wait_pos(10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        load_i  = 1'b1;
        data_i  = 16'($urandom);
        blank_i = 4'($urandom_range(0, 15));
      end else begin
        load_i  = 1'b0;
      end
      rst = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    load_i = 1'b0;
    rst    = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
